// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI shift engine
package spi_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // SPI mode encodings as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sck_divider.sv
// rtl/spi_sck_divider.sv - SCK half-period divider producing one tick per half-period
module spi_sck_divider #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] clk_div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    // Count 0..clk_div while enabled; wrap to 0 on the tick so a frame always ends with the counter at 0
    always_comb begin
        div_cnt_d = div_cnt_q;
        tick      = 1'b0;
        if (enable) begin
            if (div_cnt_q == clk_div) begin
                div_cnt_d = '0;
                tick      = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // Divider counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI serial datapath: SCK generation, MOSI shift-out, MISO capture
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              transfer_en,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              byte_done,
    output logic              busy
);

    localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    state_t              state_q,    state_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   rx_data_q,  rx_data_d;
    logic                cpol_q,     cpol_d;
    logic                cpha_q,     cpha_d;
    logic [DIV_W-1:0]    div_q,      div_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                sck_q,      sck_d;
    logic                mosi_q,     mosi_d;
    logic [EDGE_W-1:0]   edge_next;
    logic                tick;

    spi_sck_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .enable  ((state_q == SHIFT) && transfer_en),
        .clk_div (div_q),
        .tick    (tick)
    );

    // Next-state, shift and sample logic; a load with transfer_en already high skips LOADED
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        div_d      = div_q;
        edge_cnt_d = edge_cnt_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        edge_next  = edge_cnt_q + 1'b1;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (load) begin
                    state_d    = transfer_en ? SHIFT : LOADED;
                    tx_shift_d = tx_data;
                    rx_shift_d = '0;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    div_d      = clk_div;
                    edge_cnt_d = '0;
                    sck_d      = cpol;
                    mosi_d     = cpha ? 1'b0 : tx_data[DATA_W-1];
                end
            end
            LOADED: begin
                if (transfer_en) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    edge_cnt_d = edge_next;
                    sck_d      = ~sck_q;
                    if (edge_next[0]) begin
                        // leading edge
                        if (cpha_q) begin
                            mosi_d     = tx_shift_q[DATA_W-1];
                            tx_shift_d = tx_shift_q << 1;
                        end else begin
                            rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
                        end
                    end else begin
                        // trailing edge
                        if (cpha_q) begin
                            rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
                        end else if (edge_next != LAST_EDGE) begin
                            mosi_d     = tx_shift_q[DATA_W-2];
                            tx_shift_d = tx_shift_q << 1;
                        end
                    end
                    // rx_data is presented together with the rx_valid pulse in DONE
                    if (edge_next == LAST_EDGE) begin
                        state_d   = DONE;
                        rx_data_d = rx_shift_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            edge_cnt_q <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            edge_cnt_q <= edge_cnt_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
        end
    end

    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = (state_q == DONE);
    assign byte_done = (state_q == DONE);
    assign busy      = (state_q == LOADED) || (state_q == SHIFT);

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - directed self-checking bench for spi_shift_engine
module tb_spi_shift_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       transfer_en = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] clk_div = 8'h00;
    logic       loop = 1'b0;
    logic       miso_drv = 1'b0;
    logic       miso;
    logic       sck, mosi, rx_valid, byte_done, busy;
    logic [7:0] rx_data;

    int n_cmp = 0;
    int n_fail = 0;

    int frame_len, lead_cnt, rise_cnt, done_cnt, valid_cnt, busy_bad, half_bad, frozen_bad;
    logic [7:0] mosi_seq, rx_at_valid;

    assign miso = loop ? mosi : miso_drv;

    always #5 clk = ~clk;

    spi_shift_engine #(.DATA_W(8), .DIV_W(8)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .load        (load),
        .tx_data     (tx_data),
        .transfer_en (transfer_en),
        .cpol        (cpol),
        .cpha        (cpha),
        .clk_div     (clk_div),
        .miso        (miso),
        .sck         (sck),
        .mosi        (mosi),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .byte_done   (byte_done),
        .busy        (busy)
    );

    task automatic do_load(input logic [7:0] d, input logic p, input logic h, input logic [7:0] dv);
        @(posedge clk); #1;
        load = 1'b1; tx_data = d; cpol = p; cpha = h; clk_div = dv;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Observes one frame from the cycle after the load; fills the frame statistics
    task automatic watch(input logic cp, input int d, input int pause_edge, input int pause_len,
                         input int inject_edge, input int max_cycles);
        logic prev_sck, fz_sck, fz_mosi;
        int edges, last_tr, paused, post;
        bit seen;
        frame_len = 0; lead_cnt = 0; rise_cnt = 0; done_cnt = 0; valid_cnt = 0;
        busy_bad = 0; half_bad = 0; frozen_bad = 0; mosi_seq = 8'h00; rx_at_valid = 8'h00;
        prev_sck = sck; edges = 0; last_tr = 0; paused = 0; post = 0; seen = 0;
        fz_sck = 1'b0; fz_mosi = 1'b0;
        for (int i = 0; i < max_cycles && post < 3; i++) begin
            @(negedge clk);
            if (load) load = 1'b0;
            if (paused > 0) begin
                if (sck !== fz_sck || mosi !== fz_mosi) frozen_bad++;
                paused--;
                if (paused == 0) transfer_en = 1'b1;
            end
            if (sck !== prev_sck) begin
                edges++;
                if (pause_len == 0 && (i - last_tr) != d + 1) half_bad++;
                last_tr = i;
                if (sck !== cp) begin
                    lead_cnt++;
                    mosi_seq = {mosi_seq[6:0], mosi};
                end
                if (sck === 1'b1) rise_cnt++;
                if (edges == pause_edge && pause_len > 0) begin
                    transfer_en = 1'b0; paused = pause_len; fz_sck = sck; fz_mosi = mosi;
                end
                if (edges == inject_edge) begin
                    load = 1'b1; tx_data = 8'h11;
                end
            end
            prev_sck = sck;
            if (byte_done === 1'b1) begin
                done_cnt++;
                if (!seen) frame_len = i + 1;
                seen = 1;
                if (busy !== 1'b0) busy_bad++;
            end else if (!seen && busy !== 1'b1) begin
                busy_bad++;
            end
            if (rx_valid === 1'b1) begin
                valid_cnt++;
                rx_at_valid = rx_data;
            end
            if (seen) post++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (sck !== 1'b0)       begin n_fail++; $display("FAIL reset_sck got %b want 0", sck); end
        n_cmp++; if (mosi !== 1'b0)      begin n_fail++; $display("FAIL reset_mosi got %b want 0", mosi); end
        n_cmp++; if (rx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        n_cmp++; if (byte_done !== 1'b0) begin n_fail++; $display("FAIL reset_byte_done got %b want 0", byte_done); end
        n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_mode0_loop;
        loop = 1'b1; transfer_en = 1'b1;
        do_load(8'hA5, 1'b0, 1'b0, 8'd0);
        watch(1'b0, 0, 0, 0, 0, 100);
        n_cmp++; if (mosi_seq !== 8'hA5)   begin n_fail++; $display("FAIL m0_mosi_seq got %h want a5", mosi_seq); end
        n_cmp++; if (rise_cnt != 8)        begin n_fail++; $display("FAIL m0_rise_cnt got %0d want 8", rise_cnt); end
        n_cmp++; if (done_cnt != 1)        begin n_fail++; $display("FAIL m0_done_cnt got %0d want 1", done_cnt); end
        n_cmp++; if (valid_cnt != 1)       begin n_fail++; $display("FAIL m0_valid_cnt got %0d want 1", valid_cnt); end
        n_cmp++; if (rx_at_valid !== 8'hA5) begin n_fail++; $display("FAIL m0_rx_data got %h want a5", rx_at_valid); end
        n_cmp++; if (frame_len != 17)      begin n_fail++; $display("FAIL m0_frame_len got %0d want 17", frame_len); end
        n_cmp++; if (half_bad != 0)        begin n_fail++; $display("FAIL m0_half_period bad=%0d want 0", half_bad); end
        n_cmp++; if (busy_bad != 0)        begin n_fail++; $display("FAIL m0_busy bad=%0d want 0", busy_bad); end
        n_cmp++; if (sck !== 1'b0)         begin n_fail++; $display("FAIL m0_sck_idle got %b want 0", sck); end
    endtask

    task automatic test_mode3_div3;
        loop = 1'b0; miso_drv = 1'b1; transfer_en = 1'b1;
        do_load(8'h3C, 1'b1, 1'b1, 8'd3);
        n_cmp++; if (sck !== 1'b1) begin n_fail++; $display("FAIL m3_sck_idle_start got %b want 1", sck); end
        watch(1'b1, 3, 0, 0, 0, 200);
        n_cmp++; if (mosi_seq !== 8'h3C)   begin n_fail++; $display("FAIL m3_mosi_seq got %h want 3c", mosi_seq); end
        n_cmp++; if (lead_cnt != 8)        begin n_fail++; $display("FAIL m3_lead_cnt got %0d want 8", lead_cnt); end
        n_cmp++; if (rx_at_valid !== 8'hFF) begin n_fail++; $display("FAIL m3_rx_data got %h want ff", rx_at_valid); end
        n_cmp++; if (frame_len != 65)      begin n_fail++; $display("FAIL m3_frame_len got %0d want 65", frame_len); end
        n_cmp++; if (half_bad != 0)        begin n_fail++; $display("FAIL m3_half_period bad=%0d want 0", half_bad); end
        n_cmp++; if (done_cnt != 1)        begin n_fail++; $display("FAIL m3_done_cnt got %0d want 1", done_cnt); end
        n_cmp++; if (sck !== 1'b1)         begin n_fail++; $display("FAIL m3_sck_idle_end got %b want 1", sck); end
    endtask

    task automatic test_pause;
        loop = 1'b1; transfer_en = 1'b1;
        do_load(8'hF0, 1'b0, 1'b0, 8'd1);
        watch(1'b0, 1, 5, 10, 0, 200);
        n_cmp++; if (frozen_bad != 0)      begin n_fail++; $display("FAIL pause_frozen bad=%0d want 0", frozen_bad); end
        n_cmp++; if (frame_len != 43)      begin n_fail++; $display("FAIL pause_frame_len got %0d want 43", frame_len); end
        n_cmp++; if (rx_at_valid !== 8'hF0) begin n_fail++; $display("FAIL pause_rx_data got %h want f0", rx_at_valid); end
        n_cmp++; if (mosi_seq !== 8'hF0)   begin n_fail++; $display("FAIL pause_mosi_seq got %h want f0", mosi_seq); end
        n_cmp++; if (done_cnt != 1)        begin n_fail++; $display("FAIL pause_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_load_while_busy;
        loop = 1'b1; transfer_en = 1'b1;
        do_load(8'hC3, 1'b0, 1'b0, 8'd0);
        cpol = 1'b1; cpha = 1'b1; clk_div = 8'd5;
        watch(1'b0, 0, 0, 0, 3, 100);
        n_cmp++; if (rx_at_valid !== 8'hC3) begin n_fail++; $display("FAIL busy_rx_data got %h want c3", rx_at_valid); end
        n_cmp++; if (mosi_seq !== 8'hC3)   begin n_fail++; $display("FAIL busy_mosi_seq got %h want c3", mosi_seq); end
        n_cmp++; if (busy_bad != 0)        begin n_fail++; $display("FAIL busy_flag bad=%0d want 0", busy_bad); end
        n_cmp++; if (frame_len != 17)      begin n_fail++; $display("FAIL busy_frame_len got %0d want 17", frame_len); end
        n_cmp++; if (half_bad != 0)        begin n_fail++; $display("FAIL busy_cfg_change bad=%0d want 0", half_bad); end
        n_cmp++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL busy_after got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame;
        int edges, bad;
        logic prev;
        loop = 1'b0; miso_drv = 1'b1; transfer_en = 1'b1; bad = 0;
        do_load(8'h99, 1'b0, 1'b0, 8'd0);
        prev = sck; edges = 0;
        for (int i = 0; i < 40 && edges < 9; i++) begin
            @(negedge clk);
            if (sck !== prev) edges++;
            prev = sck;
        end
        n_cmp++; if (edges != 9) begin n_fail++; $display("FAIL rst_reach_edge9 got %0d want 9", edges); end
        rst_n = 1'b0; #1;
        n_cmp++; if (sck !== 1'b0)      begin n_fail++; $display("FAIL rst_sck got %b want 0", sck); end
        n_cmp++; if (mosi !== 1'b0)     begin n_fail++; $display("FAIL rst_mosi got %b want 0", mosi); end
        n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data got %h want 00", rx_data); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0 || byte_done !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0 || byte_done !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rst_no_valid bad=%0d want 0", bad); end
        loop = 1'b1;
        do_load(8'h5A, 1'b0, 1'b0, 8'd0);
        watch(1'b0, 0, 0, 0, 0, 100);
        n_cmp++; if (rx_at_valid !== 8'h5A) begin n_fail++; $display("FAIL rst_next_rx got %h want 5a", rx_at_valid); end
        n_cmp++; if (frame_len != 17)      begin n_fail++; $display("FAIL rst_next_len got %0d want 17", frame_len); end
    endtask

    task automatic test_idle_and_wait;
        int bad;
        bad = 0; transfer_en = 1'b1; loop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sck !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL idle_en_hold bad=%0d want 0", bad); end
        transfer_en = 1'b0; bad = 0;
        do_load(8'h5C, 1'b0, 1'b1, 8'd255);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sck !== 1'b0 || busy !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL loaded_wait bad=%0d want 0", bad); end
        transfer_en = 1'b1;
        watch(1'b0, 255, 0, 0, 0, 5000);
        n_cmp++; if (frame_len != 4097)    begin n_fail++; $display("FAIL maxdiv_frame_len got %0d want 4097", frame_len); end
        n_cmp++; if (rx_at_valid !== 8'h5C) begin n_fail++; $display("FAIL maxdiv_rx got %h want 5c", rx_at_valid); end
        n_cmp++; if (mosi_seq !== 8'h5C)   begin n_fail++; $display("FAIL maxdiv_mosi_seq got %h want 5c", mosi_seq); end
        n_cmp++; if (half_bad != 0)        begin n_fail++; $display("FAIL maxdiv_half bad=%0d want 0", half_bad); end
    endtask

    task automatic test_back_to_back;
        int t1, t2, t;
        logic [7:0] r1, r2;
        t1 = -1; t2 = -1; t = 0; r1 = 8'h00; r2 = 8'h00;
        loop = 1'b1; transfer_en = 1'b1;
        do_load(8'h81, 1'b0, 1'b0, 8'd1);
        for (int i = 0; i < 200 && t2 < 0; i++) begin
            @(negedge clk);
            t++;
            if (load) load = 1'b0;
            if (byte_done === 1'b1) begin
                if (t1 < 0) begin
                    t1 = t; r1 = rx_data;
                    load = 1'b1; tx_data = 8'h7E;
                end else begin
                    t2 = t; r2 = rx_data;
                end
            end
        end
        n_cmp++; if (t2 - t1 != 33) begin n_fail++; $display("FAIL b2b_spacing got %0d want 33", t2 - t1); end
        n_cmp++; if (r1 !== 8'h81)  begin n_fail++; $display("FAIL b2b_rx1 got %h want 81", r1); end
        n_cmp++; if (r2 !== 8'h7E)  begin n_fail++; $display("FAIL b2b_rx2 got %h want 7e", r2); end
    endtask

    initial begin
        test_reset();
        test_mode0_loop();
        test_mode3_div3();
        test_pause();
        test_load_while_busy();
        test_reset_mid_frame();
        test_idle_and_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
